// File: rtl/bram_arb_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_arb_pkg : shared types, constants and the round-robin pick function   |
// | Optional lock mode selected by BRAM_ARB_LOCK_EN.  Revision: 1.0            |
// +----------------------------------------------------------------------------+
package bram_arb_pkg;

  localparam int MAX_REQ = 8;
  localparam int PTR_W   = $clog2(MAX_REQ);

`ifdef BRAM_ARB_LOCK_EN
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    GRANT  = 2'd1,
    LOCKED = 2'd2
  } arb_state_t;
`else
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;
`endif

  // First active request at or after ptr, wrapping modulo n; one-hot result.
  function automatic logic [MAX_REQ-1:0] rr_pick(input logic [MAX_REQ-1:0] req,
                                                 input logic [PTR_W-1:0]   ptr,
                                                 input int unsigned        n);
    logic [MAX_REQ-1:0] pick;
    logic [PTR_W-1:0]   idx;
    logic               found;
    pick  = '0;
    found = 1'b0;
    for (int unsigned k = 0; k < MAX_REQ; k++) begin
      if (k < n) begin
        idx = PTR_W'((32'(ptr) + k) % n);
        if (!found && req[idx]) begin
          pick[idx] = 1'b1;
          found     = 1'b1;
        end
      end
    end
    return pick;
  endfunction

endpackage
`default_nettype wire

// File: rtl/rr_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | rr_arbiter : combinational round-robin picker with its priority pointer    |
// | Revision: 1.0                                                              |
// +----------------------------------------------------------------------------+
module rr_arbiter
  import bram_arb_pkg::*;
#(
  parameter int NUM_REQ = 4
) (
  input  logic               clk,
  input  logic               rstN,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic               gnt_any
);

  logic [PTR_W-1:0]   ptr_q, ptr_d, win_idx;
  logic [MAX_REQ-1:0] pick;

  always_comb begin
    pick    = rr_pick(MAX_REQ'(req), ptr_q, NUM_REQ);
    gnt     = pick[NUM_REQ-1:0];
    gnt_any = |gnt;
    win_idx = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) win_idx = PTR_W'(i);
    end
    ptr_d = ptr_q;
    if (gnt_any) ptr_d = (win_idx == PTR_W'(NUM_REQ-1)) ? '0 : win_idx + 1'b1;
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) ptr_q <= '0;
    else       ptr_q <= ptr_d;
  end

`ifndef SYNTHESIS
  always @(posedge clk) begin
    if (rstN) assert ((pick >> NUM_REQ) == '0);
  end
`endif

endmodule
`default_nettype wire

// File: rtl/bram_arbiter.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | bram_arbiter : round-robin sharing of one single-port BRAM, tagged reads   |
// | Define BRAM_ARB_LOCK_EN for bounded burst ownership.  Revision: 1.0        |
// +----------------------------------------------------------------------------+
module bram_arbiter
  import bram_arb_pkg::*;
#(
  parameter  int NUM_REQ       = 4,
  parameter  int MEMORY_DEPTH  = 4092,
  parameter  int DATA_WIDTH    = 16,
  parameter  int MAX_LOCK      = 8,
  localparam int ADDRESS_WIDTH = $clog2(MEMORY_DEPTH)
) (
  input  logic                                    clk,
  input  logic                                    rstN,
  input  logic [NUM_REQ-1:0]                      req,
  input  logic [NUM_REQ-1:0]                      req_wr,
  input  logic [NUM_REQ-1:0][ADDRESS_WIDTH-1:0]   req_addr,
  input  logic [NUM_REQ-1:0][DATA_WIDTH-1:0]      req_data,
`ifdef BRAM_ARB_LOCK_EN
  input  logic [NUM_REQ-1:0]                      req_lock,
`endif
  output logic [NUM_REQ-1:0]                      gnt,
  output logic [NUM_REQ-1:0]                      rvalid,
  output logic [DATA_WIDTH-1:0]                   rdata,
  output logic                                    mem_wr,
  output logic [ADDRESS_WIDTH-1:0]                mem_addr,
  output logic [DATA_WIDTH-1:0]                   mem_data,
  input  logic [DATA_WIDTH-1:0]                   mem_q
);

  arb_state_t                state_q, state_d;
  logic [NUM_REQ-1:0]        req_eff, arb_req, rid_q, rid_d;
  logic                      gnt_any, rd_pend_q, rd_pend_d, win_wr;
  logic [ADDRESS_WIDTH-1:0]  win_addr, addr_q, addr_d;
  logic [DATA_WIDTH-1:0]     win_data, data_q, data_d, rdata_q, rdata_d;

`ifdef BRAM_ARB_LOCK_EN
  localparam int LCW = $clog2(MAX_LOCK + 1);
  logic [NUM_REQ-1:0] owner_q, owner_d;
  logic [LCW-1:0]     lock_cnt_q, lock_cnt_d, cnt_next;
  logic               win_lock;

  // Others are only blocked while the owner is actually asking.
  assign req_eff = (state_q == LOCKED && |(req & owner_q)) ? (req & owner_q) : req;
`else
  assign req_eff = req;
`endif

  assign arb_req = rstN ? req_eff : '0;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .clk     (clk),
    .rstN    (rstN),
    .req     (arb_req),
    .gnt     (gnt),
    .gnt_any (gnt_any)
  );

  always_comb begin
    win_wr   = 1'b0;
    win_addr = '0;
    win_data = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        win_wr   = req_wr[i];
        win_addr = req_addr[i];
        win_data = req_data[i];
      end
    end
    mem_wr    = gnt_any & win_wr;
    mem_addr  = gnt_any ? win_addr : addr_q;
    mem_data  = gnt_any ? win_data : data_q;
    addr_d    = mem_addr;
    data_d    = mem_data;
    rd_pend_d = gnt_any & ~win_wr;
    rid_d     = gnt & ~req_wr;
    rvalid    = rd_pend_q ? rid_q : '0;
    // Hold the last returned word so writes leave rdata untouched.
    rdata     = rd_pend_q ? mem_q : rdata_q;
    rdata_d   = rdata;
  end

  always_comb begin
    state_d = gnt_any ? GRANT : IDLE;
`ifdef BRAM_ARB_LOCK_EN
    owner_d    = owner_q;
    lock_cnt_d = '0;
    cnt_next   = '0;
    win_lock   = |(req_lock & gnt);
    if (gnt_any) begin
      if (state_q == LOCKED && gnt == owner_q) cnt_next = lock_cnt_q + 1'b1;
      else                                     cnt_next = LCW'(1);
      // Reaching MAX_LOCK drops the lock; ptr already sits at owner+1.
      if (win_lock && cnt_next < LCW'(MAX_LOCK)) begin
        state_d    = LOCKED;
        owner_d    = gnt;
        lock_cnt_d = cnt_next;
      end
    end
`endif
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state_q   <= IDLE;
      rd_pend_q <= 1'b0;
      rid_q     <= '0;
      addr_q    <= '0;
      data_q    <= '0;
      rdata_q   <= '0;
    end else begin
      state_q   <= state_d;
      rd_pend_q <= rd_pend_d;
      rid_q     <= rid_d;
      addr_q    <= addr_d;
      data_q    <= data_d;
      rdata_q   <= rdata_d;
    end
  end

`ifdef BRAM_ARB_LOCK_EN
  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      owner_q    <= '0;
      lock_cnt_q <= '0;
    end else begin
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
    end
  end
`endif

`ifndef SYNTHESIS
  a_gnt_onehot: assert property (@(posedge clk) disable iff (!rstN) $onehot0(gnt));
  a_addr_range: assert property (@(posedge clk) disable iff (!rstN)
                                 gnt_any |-> (32'(mem_addr) < MEMORY_DEPTH));
  a_state_hist: assert property (@(posedge clk) disable iff (!rstN)
                                 (state_q != IDLE) == $past(gnt_any));
  always @(posedge clk) begin
    assert (NUM_REQ >= 2 && NUM_REQ <= MAX_REQ && MAX_LOCK >= 1);
  end
`endif

endmodule
`default_nettype wire
